// File: rtl/spi_shift_engine.sv
// Master-mode SPI shift engine: gates the free-running SCLK from the clock generator onto the pin
// for one word, shifting MOSI out MSB-first and assembling the MISO word.
module spi_shift_engine #(
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_sclk,
  input  logic              i_sclk_rising_edge,
  input  logic              i_sclk_falling_edge,
  input  logic              i_cpol,
  input  logic              i_cpha,
  input  logic              i_mstr,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_tx_data,
  input  logic              i_spif_clr,
  input  logic              i_miso,
  output logic              o_sclk,
  output logic              o_mosi,
  output logic              o_ss_n,
  output logic              o_busy,
  output logic [DATA_W-1:0] o_rx_data,
  output logic              o_done,
  output logic              o_spif,
  output logic              o_wcol
);

  localparam int CNT_W = $clog2(2*DATA_W) + 1;
  localparam logic [CNT_W-1:0] LAST_EDGE = CNT_W'(2*DATA_W - 1);

  typedef enum logic [1:0] {IDLE, SYNC, XFER, DONE} state_t;

  state_t            state;
  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-1:0] rx_shift;
  logic [DATA_W-1:0] rx_data;
  logic [CNT_W-1:0]  edge_cnt;
  logic              cpol_l;
  logic              cpha_l;
  logic              mosi;
  logic              ss_n;
  logic              busy;
  logic              done;
  logic              spif;
  logic              wcol;
  logic              lead;
  logic              trail;

  // A coincident trail strobe is dropped so lead always wins.
  assign lead  = cpol_l ? i_sclk_falling_edge : i_sclk_rising_edge;
  assign trail = (cpol_l ? i_sclk_rising_edge : i_sclk_falling_edge) & ~lead;

  // The pin only follows i_sclk once XFER starts at the idle level, so no runt pulses appear.
  always_comb begin
    o_sclk = cpol_l;
    case (state)
      IDLE:    o_sclk = i_cpol;
      XFER:    o_sclk = i_sclk;
      default: o_sclk = cpol_l;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state    <= IDLE;
      tx_shift <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
      edge_cnt <= '0;
      cpol_l   <= 1'b0;
      cpha_l   <= 1'b0;
      mosi     <= 1'b1;
      ss_n     <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      spif     <= 1'b0;
      wcol     <= 1'b0;
    end else begin
      done <= 1'b0;
      wcol <= 1'b0;
      if (i_spif_clr) spif <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start && i_mstr) begin
            tx_shift <= i_tx_data;
            rx_shift <= '0;
            cpol_l   <= i_cpol;
            cpha_l   <= i_cpha;
            edge_cnt <= '0;
            busy     <= 1'b1;
            ss_n     <= 1'b0;
            mosi     <= i_cpha ? 1'b1 : i_tx_data[DATA_W-1];
            state    <= SYNC;
          end
        end
        SYNC: begin
          if (i_start) wcol <= 1'b1;
          if (trail) begin
            edge_cnt <= '0;
            state    <= XFER;
          end
        end
        XFER: begin
          if (i_start) wcol <= 1'b1;
          if (lead) begin
            edge_cnt <= edge_cnt + CNT_W'(1);
            if (cpha_l) begin
              mosi     <= tx_shift[DATA_W-1];
              tx_shift <= tx_shift << 1;
            end else begin
              rx_shift <= {rx_shift[DATA_W-2:0], i_miso};
            end
          end else if (trail) begin
            edge_cnt <= edge_cnt + CNT_W'(1);
            if (edge_cnt == LAST_EDGE) begin
              // Final trail: in cpha=1 the last bit is sampled here and folded straight into the result.
              state <= DONE;
              done  <= 1'b1;
              spif  <= 1'b1;
              ss_n  <= 1'b1;
              busy  <= 1'b0;
              mosi  <= 1'b1;
              if (cpha_l) begin
                rx_shift <= {rx_shift[DATA_W-2:0], i_miso};
                rx_data  <= {rx_shift[DATA_W-2:0], i_miso};
              end else begin
                rx_data  <= rx_shift;
              end
            end else if (cpha_l) begin
              rx_shift <= {rx_shift[DATA_W-2:0], i_miso};
            end else begin
              mosi     <= tx_shift[DATA_W-2];
              tx_shift <= tx_shift << 1;
            end
          end
        end
        DONE: begin
          spif  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_mosi    = mosi;
  assign o_ss_n    = ss_n;
  assign o_busy    = busy;
  assign o_rx_data = rx_data;
  assign o_done    = done;
  assign o_spif    = spif;
  assign o_wcol    = wcol;

endmodule

// File: tb/tb_spi_shift_engine.sv
// Bench for spi_shift_engine: behavioural SCLK generator, pin monitor, optional slave model,
// and a scoreboard of expected RX words compared on each o_done.
module tb_spi_shift_engine;

  localparam int DATA_W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic              cpol, cpha, mstr, start, spif_clr;
  logic [DATA_W-1:0] tx_data;
  logic              sclk_o, mosi, ss_n, busy, done, spif, wcol, miso;
  logic [DATA_W-1:0] rx_data;

  int vectors    = 0;
  int miscompares = 0;
  logic [DATA_W-1:0] sb[$];

  // SCLK generator: half period of 4 clk cycles, strobes valid in the cycle after SCLK changes.
  logic gen_base = 1'b0;
  logic sclk_d   = 1'b0;
  int   gen_div  = 0;
  logic sclk_gen, rise, fall;
  assign sclk_gen = gen_base ^ cpol;
  assign rise     = sclk_gen & ~sclk_d;
  assign fall     = ~sclk_gen & sclk_d;
  always @(posedge clk) begin
    sclk_d <= sclk_gen;
    if (gen_div == 3) begin
      gen_div  <= 0;
      gen_base <= ~gen_base;
    end else begin
      gen_div <= gen_div + 1;
    end
  end

  // Slave model: drives pat_word MSB-first, changing on each lead edge seen on the pin.
  logic              pat_en   = 1'b0;
  logic [DATA_W-1:0] pat_word = '0;
  logic              miso_pat = 1'b0;
  logic              slv_sclk = 1'b0;
  int                pat_idx  = DATA_W - 1;
  always @(negedge clk) begin
    if (ss_n) pat_idx = DATA_W - 1;
    else if (sclk_o !== slv_sclk && sclk_o === ~cpol && pat_idx >= 0) begin
      miso_pat = pat_word[pat_idx];
      pat_idx--;
    end
    slv_sclk = sclk_o;
  end
  assign miso = pat_en ? miso_pat : mosi;

  // Pin monitor: counts SCLK edges while selected, short levels, and MOSI changes on the wrong phase.
  int   edge_total = 0, rise_total = 0, runt_total = 0, mosi_bad = 0, run_len = 0;
  logic mon_sclk = 1'b0, mon_mosi = 1'b1, mon_ss = 1'b1;
  always @(negedge clk) begin
    if (sclk_o !== mon_sclk) begin
      if (!ss_n) begin
        edge_total++;
        if (sclk_o) rise_total++;
        if (run_len < 4) runt_total++;
      end
      run_len = 1;
    end else begin
      run_len++;
    end
    if (!ss_n && !mon_ss && mosi !== mon_mosi && sclk_o !== (cpha ? ~cpol : cpol)) mosi_bad++;
    mon_sclk = sclk_o;
    mon_mosi = mosi;
    mon_ss   = ss_n;
  end

  spi_shift_engine #(.DATA_W(DATA_W)) dut (
    .i_clk               (clk),
    .i_reset_n           (rst_n),
    .i_sclk              (sclk_gen),
    .i_sclk_rising_edge  (rise),
    .i_sclk_falling_edge (fall),
    .i_cpol              (cpol),
    .i_cpha              (cpha),
    .i_mstr              (mstr),
    .i_start             (start),
    .i_tx_data           (tx_data),
    .i_spif_clr          (spif_clr),
    .i_miso              (miso),
    .o_sclk              (sclk_o),
    .o_mosi              (mosi),
    .o_ss_n              (ss_n),
    .o_busy              (busy),
    .o_rx_data           (rx_data),
    .o_done              (done),
    .o_spif              (spif),
    .o_wcol              (wcol)
  );

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic set_mode(input logic pol, input logic pha);
    @(negedge clk);
    cpol = pol;
    cpha = pha;
    idle_cycles(10);
  endtask

  task automatic do_start(input logic [DATA_W-1:0] tx, input logic [DATA_W-1:0] exp);
    @(negedge clk);
    tx_data = tx;
    start   = 1'b1;
    sb.push_back(exp);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL done_timeout: o_done not seen within 300 cycles, required a pulse");
    end
  endtask

  task automatic test_reset();
    vectors++;
    if ({mosi, ss_n, busy, done, spif, wcol} !== 6'b110000) begin
      miscompares++;
      $display("FAIL reset_flags: {mosi,ss_n,busy,done,spif,wcol}=%b required 110000",
               {mosi, ss_n, busy, done, spif, wcol});
    end
    vectors++;
    if (rx_data !== '0) begin
      miscompares++;
      $display("FAIL reset_rx: rx_data=%h required 00", rx_data);
    end
    vectors++;
    if (sclk_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_sclk_cpol0: sclk=%b required 0", sclk_o);
    end
    cpol = 1'b1;
    #1;
    vectors++;
    if (sclk_o !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_sclk_cpol1: sclk=%b required 1", sclk_o);
    end
    cpol = 1'b0;
    $display("reset: outputs checked with rst_n low");
  endtask

  task automatic test_mode0();
    bit ok;
    int e0, r0, m0;
    logic [DATA_W-1:0] exp;
    set_mode(1'b0, 1'b0);
    e0 = edge_total; r0 = rise_total; m0 = mosi_bad;
    vectors++;
    if (sclk_o !== 1'b0) begin
      miscompares++;
      $display("FAIL mode0_idle_before: sclk=%b required 0", sclk_o);
    end
    do_start(8'hA5, 8'hA5);
    wait_done(ok);
    exp = sb.pop_front();
    if (ok) begin
      vectors++;
      if (rx_data !== exp) begin
        miscompares++;
        $display("FAIL mode0_rx: rx=%h required %h", rx_data, exp);
      end
      vectors++;
      if (spif !== 1'b1) begin
        miscompares++;
        $display("FAIL mode0_spif: spif=%b required 1", spif);
      end
      @(negedge clk);
      vectors++;
      if (done !== 1'b0) begin
        miscompares++;
        $display("FAIL mode0_done_width: done=%b one cycle later, required 0", done);
      end
    end
    idle_cycles(4);
    vectors++;
    if (edge_total - e0 !== 16 || rise_total - r0 !== 8) begin
      miscompares++;
      $display("FAIL mode0_edges: edges=%0d rising=%0d required 16/8", edge_total - e0, rise_total - r0);
    end
    vectors++;
    if (sclk_o !== 1'b0 || mosi_bad - m0 !== 0) begin
      miscompares++;
      $display("FAIL mode0_idle_after: sclk=%b mosi_bad=%0d required 0/0", sclk_o, mosi_bad - m0);
    end
    $display("mode0: tx=a5 rx=%h", rx_data);
  endtask

  task automatic test_mode3();
    bit ok;
    int e0, m0;
    logic [DATA_W-1:0] exp;
    set_mode(1'b1, 1'b1);
    pat_word = 8'hC3;
    pat_en   = 1'b1;
    e0 = edge_total; m0 = mosi_bad;
    vectors++;
    if (sclk_o !== 1'b1) begin
      miscompares++;
      $display("FAIL mode3_idle_before: sclk=%b required 1", sclk_o);
    end
    do_start(8'h3C, 8'hC3);
    wait_done(ok);
    exp = sb.pop_front();
    if (ok) begin
      vectors++;
      if (rx_data !== exp) begin
        miscompares++;
        $display("FAIL mode3_rx: rx=%h required %h", rx_data, exp);
      end
    end
    idle_cycles(4);
    vectors++;
    if (edge_total - e0 !== 16 || sclk_o !== 1'b1) begin
      miscompares++;
      $display("FAIL mode3_edges: edges=%0d sclk=%b required 16/1", edge_total - e0, sclk_o);
    end
    vectors++;
    if (mosi_bad - m0 !== 0) begin
      miscompares++;
      $display("FAIL mode3_mosi_phase: bad_changes=%0d required 0", mosi_bad - m0);
    end
    pat_en = 1'b0;
    $display("mode3: tx=3c rx=%h", rx_data);
  endtask

  task automatic test_modes12();
    bit ok;
    int e0, t0;
    logic [DATA_W-1:0] exp;
    for (int m = 1; m <= 2; m++) begin
      set_mode(m == 2, m == 1);
      e0 = edge_total; t0 = runt_total;
      do_start(8'h81, 8'h81);
      wait_done(ok);
      exp = sb.pop_front();
      if (ok) begin
        vectors++;
        if (rx_data !== exp) begin
          miscompares++;
          $display("FAIL mode%0d_rx: rx=%h required %h", m, rx_data, exp);
        end
      end
      idle_cycles(4);
      vectors++;
      if (edge_total - e0 !== 16 || runt_total - t0 !== 0) begin
        miscompares++;
        $display("FAIL mode%0d_gating: edges=%0d runts=%0d required 16/0", m, edge_total - e0, runt_total - t0);
      end
      $display("mode%0d: tx=81 rx=%h", m, rx_data);
    end
  endtask

  task automatic test_collision();
    bit ok;
    bit saw_busy;
    logic [DATA_W-1:0] exp;
    set_mode(1'b0, 1'b0);
    do_start(8'h81, 8'h81);
    idle_cycles(20);
    tx_data = 8'hFF;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    vectors++;
    if (wcol !== 1'b1) begin
      miscompares++;
      $display("FAIL wcol_pulse: wcol=%b required 1", wcol);
    end
    @(negedge clk);
    vectors++;
    if (wcol !== 1'b0) begin
      miscompares++;
      $display("FAIL wcol_width: wcol=%b required 0", wcol);
    end
    wait_done(ok);
    exp = sb.pop_front();
    if (ok) begin
      vectors++;
      if (rx_data !== exp) begin
        miscompares++;
        $display("FAIL wcol_rx: rx=%h required %h", rx_data, exp);
      end
    end
    @(negedge clk);
    saw_busy = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || ss_n !== 1'b1) saw_busy = 1'b1;
    end
    vectors++;
    if (saw_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL wcol_no_restart: activity=%b required 0", saw_busy);
    end
    $display("collision: first rx=%h", rx_data);
  endtask

  task automatic test_reset_mid();
    bit ok;
    int e0;
    logic [DATA_W-1:0] exp;
    set_mode(1'b0, 1'b0);
    e0 = edge_total;
    do_start(8'h96, 8'h96);
    for (int i = 0; i < 200 && (edge_total - e0) < 7; i++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp = sb.pop_front();
    vectors++;
    if (ss_n !== 1'b1 || busy !== 1'b0 || sclk_o !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_pins: ss_n=%b busy=%b sclk=%b required 1/0/0", ss_n, busy, sclk_o);
    end
    vectors++;
    if (rx_data !== '0) begin
      miscompares++;
      $display("FAIL midreset_rx: rx=%h required 00", rx_data);
    end
    idle_cycles(3);
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_done: done=%b required 0", done);
    end
    rst_n = 1'b1;
    idle_cycles(5);
    do_start(8'h5A, 8'h5A);
    wait_done(ok);
    exp = sb.pop_front();
    if (ok) begin
      vectors++;
      if (rx_data !== exp) begin
        miscompares++;
        $display("FAIL midreset_next_rx: rx=%h required %h", rx_data, exp);
      end
    end
    $display("reset_mid: aborted 96, next rx=%h", rx_data);
  endtask

  task automatic test_spif();
    bit ok;
    bit act;
    int e0;
    logic [DATA_W-1:0] exp;
    @(negedge clk);
    spif_clr = 1'b1;
    @(negedge clk);
    spif_clr = 1'b0;
    vectors++;
    if (spif !== 1'b0) begin
      miscompares++;
      $display("FAIL spif_clear_idle: spif=%b required 0", spif);
    end
    do_start(8'h3E, 8'h3E);
    wait_done(ok);
    exp = sb.pop_front();
    spif_clr = 1'b1;
    @(negedge clk);
    vectors++;
    if (spif !== 1'b1) begin
      miscompares++;
      $display("FAIL spif_set_wins: spif=%b required 1", spif);
    end
    @(negedge clk);
    spif_clr = 1'b0;
    vectors++;
    if (spif !== 1'b0) begin
      miscompares++;
      $display("FAIL spif_clear_after: spif=%b required 0", spif);
    end
    if (ok) begin
      vectors++;
      if (rx_data !== exp) begin
        miscompares++;
        $display("FAIL spif_rx: rx=%h required %h", rx_data, exp);
      end
    end
    e0 = edge_total;
    mstr    = 1'b0;
    tx_data = 8'hFF;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    act = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (busy !== 1'b0 || ss_n !== 1'b1 || wcol !== 1'b0 || done !== 1'b0) act = 1'b1;
      @(negedge clk);
    end
    vectors++;
    if (act !== 1'b0 || edge_total - e0 !== 0) begin
      miscompares++;
      $display("FAIL mstr_off: activity=%b edges=%0d required 0/0", act, edge_total - e0);
    end
    mstr = 1'b1;
    $display("spif: rx=%h, mstr=0 start ignored", rx_data);
  endtask

  initial begin
    rst_n    = 1'b0;
    cpol     = 1'b0;
    cpha     = 1'b0;
    mstr     = 1'b1;
    start    = 1'b0;
    spif_clr = 1'b0;
    tx_data  = '0;
    idle_cycles(3);
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(3);
    test_mode0();
    test_mode3();
    test_modes12();
    test_collision();
    test_reset_mid();
    test_spif();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
